hazard_unit: RTL

Pipeline hazard controller for the 5-stage core. It generates the select codes for the execute-stage operand forwarding muxes and the decode-stage branch comparator forwarding. It also generates the fetch/decode stall and decode/execute flush controls. The block keeps its own shadow copy of the E/M/W destination-register scoreboard and a busy counter for the multi-cycle multiply/divide unit. Decode-stage fields are the only per-instruction inputs.

---
 rtl/hazard_pkg.sv | 32 +++
 rtl/md_busy_counter.sv | 35 +++
 rtl/hazard_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
//==============================================================
// hazard_pkg - shared forward encodings and scoreboard entry, rev 1.0
//==============================================================
`default_nettype none

package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wr;
    logic       reg_write;
    logic       mem_to_reg;
    logic       md_start;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  // $0 is hardwired, so a write to it can never satisfy a consumer.
  function automatic logic reg_match(input logic [4:0] dst,
                                     input logic       we,
                                     input logic [4:0] src);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_busy_counter.sv
//==============================================================
// md_busy_counter - mult/div occupancy counter and busy flag, rev 1.0
//==============================================================
`default_nettype none

module md_busy_counter #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start_e,
  output logic md_busy
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MD_LATENCY - 1);

  logic [CNT_W-1:0] cnt;

  // The start cycle itself counts as busy, so the reload is one short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (md_start_e) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign md_busy = (cnt != '0) || md_start_e;

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
//==============================================================
// hazard_unit - forwarding, stall and flush control, rev 1.0
//==============================================================
`default_nettype none

module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic       UseRsD,
  input  logic       UseRtD,
  input  logic [4:0] WriteRegD,
  input  logic       RegWriteD,
  input  logic       MemtoRegD,
  input  logic       BranchD,
  input  logic       MDStartD,
  input  logic       MDReadD,
  input  logic       PCSrcD,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       MDBusy
);

  sb_entry_t  dec_entry;
  sb_entry_t  ex_entry;
  logic [4:0] mem_wr;
  logic       mem_rw;
  logic       mem_mtr;
  logic [4:0] wb_wr;
  logic       wb_rw;

  logic       lw_stall;
  logic       br_stall;
  logic       md_stall;
  logic       stall;
  logic       md_busy;

  always_comb begin
    dec_entry            = SB_BUBBLE;
    dec_entry.rs         = RsD;
    dec_entry.rt         = RtD;
    dec_entry.wr         = WriteRegD;
    dec_entry.reg_write  = RegWriteD;
    dec_entry.mem_to_reg = MemtoRegD;
    dec_entry.md_start   = MDStartD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_entry <= SB_BUBBLE;
      mem_wr   <= 5'd0;
      mem_rw   <= 1'b0;
      mem_mtr  <= 1'b0;
      wb_wr    <= 5'd0;
      wb_rw    <= 1'b0;
    end else begin
      ex_entry <= stall ? SB_BUBBLE : dec_entry;
      mem_wr   <= ex_entry.wr;
      mem_rw   <= ex_entry.reg_write;
      mem_mtr  <= ex_entry.mem_to_reg;
      wb_wr    <= mem_wr;
      wb_rw    <= mem_rw;
    end
  end

  // M is checked first so the youngest producer wins.
  always_comb begin
    ForwardAE = FWD_RF;
    if (reg_match(mem_wr, mem_rw, ex_entry.rs)) begin
      ForwardAE = FWD_MEM;
    end else if (reg_match(wb_wr, wb_rw, ex_entry.rs)) begin
      ForwardAE = FWD_WB;
    end
  end

  always_comb begin
    ForwardBE = FWD_RF;
    if (reg_match(mem_wr, mem_rw, ex_entry.rt)) begin
      ForwardBE = FWD_MEM;
    end else if (reg_match(wb_wr, wb_rw, ex_entry.rt)) begin
      ForwardBE = FWD_WB;
    end
  end

  assign ForwardAD = reg_match(mem_wr, mem_rw, RsD) && !mem_mtr;
  assign ForwardBD = reg_match(mem_wr, mem_rw, RtD) && !mem_mtr;

  assign lw_stall = ex_entry.mem_to_reg &&
                    ((UseRsD && reg_match(ex_entry.wr, ex_entry.reg_write, RsD)) ||
                     (UseRtD && reg_match(ex_entry.wr, ex_entry.reg_write, RtD)));

  // Branch compares in D, so a load in M is still too late to forward.
  assign br_stall = BranchD &&
                    (reg_match(ex_entry.wr, ex_entry.reg_write, RsD) ||
                     reg_match(ex_entry.wr, ex_entry.reg_write, RtD) ||
                     (mem_mtr && (reg_match(mem_wr, mem_rw, RsD) ||
                                  reg_match(mem_wr, mem_rw, RtD))));

  assign md_stall = (MDStartD || MDReadD) && md_busy;
  assign stall    = lw_stall || br_stall || md_stall;

  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;
  assign FlushD = PCSrcD && !stall;
  assign MDBusy = md_busy;

  md_busy_counter #(
    .MD_LATENCY (MD_LATENCY),
    .CNT_W      (CNT_W)
  ) u_md_busy_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .md_start_e (ex_entry.md_start),
    .md_busy    (md_busy)
  );

endmodule

`default_nettype wire
